param_lifo_stack: RTL and testbench

//  Parametrised LIFO stack: configurable data width and depth, with full/empty

---
 rtl/param_lifo_stack.sv | 143 ++++++++++++++
 tb/tb_param_lifo_stack.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with full/empty flags, occupancy count, top-of-stack peek,
// registered pop data with a valid strobe, replace-top on push+pop, and sticky error flags.
module param_lifo_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH + 1)
) (
    input  logic             p_reset,
    input  logic             m_clock,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top_data,
    output logic [AW-1:0]    count,
    output logic             is_empty,
    output logic             is_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_count;
    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_top_word;
    logic             w_mem_we;
    logic [IW-1:0]    w_mem_idx;

    // Occupancy flags and storage indices; the top index is only used when non-empty.
    always_comb begin
        w_empty    = (r_count == {AW{1'b0}});
        w_full     = (r_count == AW'(DEPTH));
        w_top_idx  = IW'(r_count - AW'(1));
        w_wr_idx   = IW'(r_count);
        w_top_word = r_mem[w_top_idx];
    end

    // Storage write decode: a plain push fills the next slot, push+pop overwrites the top.
    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_idx = w_wr_idx;
        if (p_reset && !clear) begin
            if (push && !pop && !w_full) begin
                w_mem_we  = 1'b1;
                w_mem_idx = w_wr_idx;
            end else if (push && pop && !w_empty) begin
                w_mem_we  = 1'b1;
                w_mem_idx = w_top_idx;
            end else begin
                w_mem_we  = 1'b0;
                w_mem_idx = w_wr_idx;
            end
        end else begin
            w_mem_we  = 1'b0;
            w_mem_idx = w_wr_idx;
        end
    end

    // Storage array: contents are not reset; the count alone defines what is valid.
    always_ff @(posedge m_clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= push_data;
        end
    end

    // Control state: count, pop data/strobe and sticky error flags.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_count     <= {AW{1'b0}};
            r_pop_data  <= {WIDTH{1'b0}};
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_count     <= {AW{1'b0}};
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    r_pop_valid <= 1'b0;
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + AW'(1);
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        r_pop_valid <= 1'b0;
                        r_underflow <= 1'b1;
                    end else begin
                        r_pop_data  <= w_top_word;
                        r_pop_valid <= 1'b1;
                        r_count     <= r_count - AW'(1);
                    end
                end
                2'b11: begin
                    // Empty stack: the pushed word bypasses storage straight to pop_data.
                    r_pop_valid <= 1'b1;
                    if (w_empty) begin
                        r_pop_data <= push_data;
                    end else begin
                        r_pop_data <= w_top_word;
                    end
                end
                default: begin
                    r_pop_valid <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        pop_data  = r_pop_data;
        pop_valid = r_pop_valid;
        count     = r_count;
        is_empty  = w_empty;
        is_full   = w_full;
        overflow  = r_overflow;
        underflow = r_underflow;
        if (w_empty) begin
            top_data = {WIDTH{1'b0}};
        end else begin
            top_data = w_top_word;
        end
    end

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed self-checking bench for param_lifo_stack: DEPTH=4/WIDTH=8 instance plus a
// DEPTH=5/WIDTH=16 instance for the non-power-of-2 case.
module tb_param_lifo_stack;

    logic        m_clock = 1'b0;
    logic        p_reset = 1'b1;

    logic        clear = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0]  push_data = 8'h00;
    logic [7:0]  pop_data, top_data;
    logic        pop_valid, is_empty, is_full, overflow, underflow;
    logic [2:0]  count;

    logic        clear2 = 1'b0, push2 = 1'b0, pop2 = 1'b0;
    logic [15:0] push_data2 = 16'h0000;
    logic [15:0] pop_data2, top_data2;
    logic        pop_valid2, is_empty2, is_full2, overflow2, underflow2;
    logic [2:0]  count2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 m_clock = ~m_clock;

    param_lifo_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .p_reset(p_reset), .m_clock(m_clock), .clear(clear),
        .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .top_data(top_data),
        .count(count), .is_empty(is_empty), .is_full(is_full),
        .overflow(overflow), .underflow(underflow)
    );

    param_lifo_stack #(.WIDTH(16), .DEPTH(5)) dut5 (
        .p_reset(p_reset), .m_clock(m_clock), .clear(clear2),
        .push(push2), .push_data(push_data2), .pop(pop2),
        .pop_data(pop_data2), .pop_valid(pop_valid2), .top_data(top_data2),
        .count(count2), .is_empty(is_empty2), .is_full(is_full2),
        .overflow(overflow2), .underflow(underflow2)
    );

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic test_reset();
        #2 p_reset = 1'b0;
        #3;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_cmp++; if (pop_data !== 8'h00) begin n_err++; $display("FAIL rst_pop_data: got %0h expected 00", pop_data); end
        n_cmp++; if (pop_valid !== 1'b0) begin n_err++; $display("FAIL rst_pop_valid: got %0b expected 0", pop_valid); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL rst_errflags: got %0b expected 00", {overflow, underflow}); end
        n_cmp++; if ({is_empty, is_full} !== 2'b10) begin n_err++; $display("FAIL rst_flags: got %0b expected 10", {is_empty, is_full}); end
        n_cmp++; if (top_data !== 8'h00) begin n_err++; $display("FAIL rst_top: got %0h expected 00", top_data); end
        @(negedge m_clock);
        p_reset = 1'b1;
        tick();
    endtask

    task automatic test_push_pop();
        push = 1'b1;
        push_data = 8'h11; tick();
        push_data = 8'h22; tick();
        push_data = 8'h33; tick();
        push = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pp_count: got %0d expected 3", count); end
        n_cmp++; if (top_data !== 8'h33) begin n_err++; $display("FAIL pp_top: got %0h expected 33", top_data); end
        pop = 1'b1;
        tick();
        n_cmp++; if ({pop_valid, pop_data} !== {1'b1, 8'h33}) begin n_err++; $display("FAIL pp_pop1: got %0b/%0h expected 1/33", pop_valid, pop_data); end
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL pp_count_after_pop: got %0d expected 2", count); end
        tick();
        n_cmp++; if ({pop_valid, pop_data} !== {1'b1, 8'h22}) begin n_err++; $display("FAIL pp_pop2: got %0b/%0h expected 1/22", pop_valid, pop_data); end
        tick();
        pop = 1'b0;
        n_cmp++; if ({pop_valid, pop_data} !== {1'b1, 8'h11}) begin n_err++; $display("FAIL pp_pop3: got %0b/%0h expected 1/11", pop_valid, pop_data); end
        n_cmp++; if (is_empty !== 1'b1) begin n_err++; $display("FAIL pp_empty: got %0b expected 1", is_empty); end
        tick();
        n_cmp++; if (pop_valid !== 1'b0) begin n_err++; $display("FAIL pp_valid_drop: got %0b expected 0", pop_valid); end
    endtask

    task automatic test_overflow();
        push = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_data = 8'(i);
            tick();
        end
        n_cmp++; if (is_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %0b expected 1", is_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %0b expected 0", overflow); end
        push_data = 8'h55;
        tick();
        push = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d expected 4", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        n_cmp++; if (top_data !== 8'h04) begin n_err++; $display("FAIL ovf_top: got %0h expected 04", top_data); end
        tick();
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if ({count, overflow} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL ovf_clear: got %0d/%0b expected 0/0", count, overflow); end
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_cmp++; if (pop_valid !== 1'b0) begin n_err++; $display("FAIL udf_valid: got %0b expected 0", pop_valid); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag: got %0b expected 1", underflow); end
        n_cmp++; if (pop_data !== 8'h11) begin n_err++; $display("FAIL udf_hold: got %0h expected 11", pop_data); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL udf_count: got %0d expected 0", count); end
        tick();
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_sticky: got %0b expected 1", underflow); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear: got %0b expected 0", underflow); end
    endtask

    task automatic test_replace_top();
        push = 1'b1; push_data = 8'hA0; tick();
        pop = 1'b1;  push_data = 8'hB0; tick();
        pop = 1'b0;  push = 1'b0;
        n_cmp++; if ({pop_valid, pop_data} !== {1'b1, 8'hA0}) begin n_err++; $display("FAIL rep_pop: got %0b/%0h expected 1/a0", pop_valid, pop_data); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL rep_count: got %0d expected 1", count); end
        n_cmp++; if (top_data !== 8'hB0) begin n_err++; $display("FAIL rep_top: got %0h expected b0", top_data); end
        push = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push_data = 8'(i);
            tick();
        end
        pop = 1'b1; push_data = 8'hC0; tick();
        pop = 1'b0; push = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rep_full_ovf: got %0b expected 0", overflow); end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL rep_full_count: got %0d expected 4", count); end
        n_cmp++; if ({pop_valid, pop_data} !== {1'b1, 8'h03}) begin n_err++; $display("FAIL rep_full_pop: got %0b/%0h expected 1/03", pop_valid, pop_data); end
        n_cmp++; if (top_data !== 8'hC0) begin n_err++; $display("FAIL rep_full_top: got %0h expected c0", top_data); end
        pop = 1'b1; tick(); pop = 1'b0;
        n_cmp++; if (top_data !== 8'h02) begin n_err++; $display("FAIL rep_below_top: got %0h expected 02", top_data); end
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_bypass();
        push = 1'b1; pop = 1'b1; push_data = 8'h7E;
        tick();
        push = 1'b0; pop = 1'b0;
        n_cmp++; if ({pop_valid, pop_data} !== {1'b1, 8'h7E}) begin n_err++; $display("FAIL byp_pop: got %0b/%0h expected 1/7e", pop_valid, pop_data); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL byp_count: got %0d expected 0", count); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL byp_udf: got %0b expected 0", underflow); end
    endtask

    task automatic test_async_reset();
        push = 1'b1;
        push_data = 8'h5A; tick();
        push_data = 8'h6B; tick();
        push = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL ar_pre_count: got %0d expected 2", count); end
        #2 p_reset = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL ar_count: got %0d expected 0", count); end
        n_cmp++; if (pop_data !== 8'h00) begin n_err++; $display("FAIL ar_pop_data: got %0h expected 00", pop_data); end
        n_cmp++; if ({pop_valid, overflow, underflow, is_empty} !== 4'b0001) begin n_err++; $display("FAIL ar_flags: got %0b expected 0001", {pop_valid, overflow, underflow, is_empty}); end
        n_cmp++; if (top_data !== 8'h00) begin n_err++; $display("FAIL ar_top: got %0h expected 00", top_data); end
        @(negedge m_clock);
        p_reset = 1'b1;
        tick();
    endtask

    task automatic test_depth5();
        push2 = 1'b1;
        push_data2 = 16'h1111; tick();
        push_data2 = 16'h2222; tick();
        push_data2 = 16'h3333; tick();
        push2 = 1'b0;
        n_cmp++; if ({count2, top_data2} !== {3'd3, 16'h3333}) begin n_err++; $display("FAIL d5_push: got %0d/%0h expected 3/3333", count2, top_data2); end
        pop2 = 1'b1;
        tick();
        n_cmp++; if ({pop_valid2, pop_data2} !== {1'b1, 16'h3333}) begin n_err++; $display("FAIL d5_pop1: got %0b/%0h expected 1/3333", pop_valid2, pop_data2); end
        tick();
        n_cmp++; if ({pop_valid2, pop_data2} !== {1'b1, 16'h2222}) begin n_err++; $display("FAIL d5_pop2: got %0b/%0h expected 1/2222", pop_valid2, pop_data2); end
        tick();
        pop2 = 1'b0;
        n_cmp++; if ({pop_valid2, pop_data2} !== {1'b1, 16'h1111}) begin n_err++; $display("FAIL d5_pop3: got %0b/%0h expected 1/1111", pop_valid2, pop_data2); end
        n_cmp++; if (is_empty2 !== 1'b1) begin n_err++; $display("FAIL d5_empty: got %0b expected 1", is_empty2); end
        push2 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_data2 = 16'(i * 16'h0101);
            tick();
        end
        n_cmp++; if ({count2, is_full2} !== {3'd4, 1'b0}) begin n_err++; $display("FAIL d5_four: got %0d/%0b expected 4/0", count2, is_full2); end
        push_data2 = 16'h0505; tick();
        n_cmp++; if ({count2, is_full2, overflow2} !== {3'd5, 1'b1, 1'b0}) begin n_err++; $display("FAIL d5_full: got %0d/%0b/%0b expected 5/1/0", count2, is_full2, overflow2); end
        push_data2 = 16'hFFFF; tick();
        push2 = 1'b0;
        n_cmp++; if ({count2, overflow2, top_data2} !== {3'd5, 1'b1, 16'h0505}) begin n_err++; $display("FAIL d5_ovf: got %0d/%0b/%0h expected 5/1/0505", count2, overflow2, top_data2); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace_top();
        test_bypass();
        test_async_reset();
        test_depth5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
